key_cmd_decoder: RTL

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/game_pkg.sv | 39 +++
 rtl/key_cmd_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared constants for the keyboard command path and the square-movement
// logic: raw key byte values, direction encodings and command codes.
// -----------------------------------------------------------------------------
package game_pkg;

   // Raw key bytes as delivered by the UART receiver
   localparam logic [7:0] KEY_ESC      = 8'h1B;
   localparam logic [7:0] KEY_LBRACKET = 8'h5B;  // '[' introduces a CSI sequence
   localparam logic [7:0] KEY_ARR_UP   = 8'h41;  // 'A' in ESC [ A
   localparam logic [7:0] KEY_ARR_DOWN = 8'h42;  // 'B'
   localparam logic [7:0] KEY_ARR_RGHT = 8'h43;  // 'C'
   localparam logic [7:0] KEY_ARR_LEFT = 8'h44;  // 'D'
   localparam logic [7:0] KEY_SPACE    = 8'h20;
   localparam logic [7:0] KEY_W        = 8'h77;
   localparam logic [7:0] KEY_A        = 8'h61;
   localparam logic [7:0] KEY_S        = 8'h73;
   localparam logic [7:0] KEY_D        = 8'h64;

   // Direction encodings held by the movement logic
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_RIGHT = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   // Command codes; a direction command's low two bits equal its direction
   localparam logic [2:0] CMD_UP    = {1'b0, DIR_UP};
   localparam logic [2:0] CMD_DOWN  = {1'b0, DIR_DOWN};
   localparam logic [2:0] CMD_RIGHT = {1'b0, DIR_RIGHT};
   localparam logic [2:0] CMD_LEFT  = {1'b0, DIR_LEFT};
   localparam logic [2:0] CMD_STOP  = 3'd4;

   // True for commands that set a direction (everything except stop)
   function automatic logic is_move(input logic [2:0] code);
      return code != CMD_STOP;
   endfunction

endpackage

// File: rtl/key_cmd_decoder.sv
// -----------------------------------------------------------------------------
// key_cmd_decoder
// Turns the byte stream from a UART receiver into movement commands.
// Accepts arrow keys (ESC [ A..D), optional w/a/s/d keys and space (stop).
// Escape sequences whose bytes arrive too far apart are abandoned with o_err.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   i_wr         byte-ready level; a byte is taken on its rising edge
//   i_data       received byte, valid while i_wr is high
//   o_dir        held direction (0 up, 1 down, 2 right, 3 left)
//   o_moving     high while o_dir applies, low after a stop command
//   o_cmd_valid  one-cycle pulse per decoded command
//   o_cmd_code   code of the last command (0..3 direction, 4 stop)
//   o_err        one-cycle pulse on malformed or timed-out sequence
//   o_last_byte  last accepted raw byte
// -----------------------------------------------------------------------------
module key_cmd_decoder
   import game_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int WASD_EN        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic [1:0] o_dir,
   output logic       o_moving,
   output logic       o_cmd_valid,
   output logic [2:0] o_cmd_code,
   output logic       o_err,
   output logic [7:0] o_last_byte
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ESC  = 2'd1;
   localparam logic [1:0] ST_CSI  = 2'd2;

   // Guard keeps the counter at least one bit wide for degenerate settings
   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wr_q;
   logic [1:0]       r_dir;
   logic             r_moving;
   logic             r_cmd_valid;
   logic [2:0]       r_cmd_code;
   logic             r_err;
   logic [7:0]       r_last_byte;

   logic             w_strobe;
   logic             w_timeout;
   logic [1:0]       w_next_state;
   logic             w_fire;
   logic [2:0]       w_code;
   logic             w_err;

   // r_wr_q comes out of reset high so a level already high is not a byte
   assign w_strobe  = i_wr & ~r_wr_q;
   // A byte arriving in the expiry cycle wins over the timeout
   assign w_timeout = (r_state != ST_IDLE) && (r_cnt == TIMEOUT_MAX) && !w_strobe;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_next_state = r_state;
      w_fire       = 1'b0;
      w_code       = CMD_STOP;
      w_err        = 1'b0;
      if (w_strobe) begin
         case (r_state)
            ST_IDLE: begin
               if (i_data == KEY_ESC) begin
                  w_next_state = ST_ESC;
               end else if (i_data == KEY_SPACE) begin
                  w_fire = 1'b1;
                  w_code = CMD_STOP;
               end else if (WASD_EN != 0) begin
                  case (i_data)
                     KEY_W:   begin w_fire = 1'b1; w_code = CMD_UP;    end
                     KEY_S:   begin w_fire = 1'b1; w_code = CMD_DOWN;  end
                     KEY_D:   begin w_fire = 1'b1; w_code = CMD_RIGHT; end
                     KEY_A:   begin w_fire = 1'b1; w_code = CMD_LEFT;  end
                     default: ;  // unknown keys are ignored silently
                  endcase
               end
            end
            ST_ESC: begin
               if (i_data == KEY_LBRACKET) begin
                  w_next_state = ST_CSI;
               end else if (i_data == KEY_ESC) begin
                  w_next_state = ST_ESC;  // repeated ESC restarts the sequence
               end else begin
                  w_next_state = ST_IDLE;
                  w_err        = 1'b1;
               end
            end
            ST_CSI: begin
               w_next_state = ST_IDLE;
               case (i_data)
                  KEY_ARR_UP:   begin w_fire = 1'b1; w_code = CMD_UP;    end
                  KEY_ARR_DOWN: begin w_fire = 1'b1; w_code = CMD_DOWN;  end
                  KEY_ARR_RGHT: begin w_fire = 1'b1; w_code = CMD_RIGHT; end
                  KEY_ARR_LEFT: begin w_fire = 1'b1; w_code = CMD_LEFT;  end
                  KEY_ESC: begin
                     w_next_state = ST_ESC;
                     w_err        = 1'b1;
                  end
                  default: w_err = 1'b1;
               endcase
            end
            default: w_next_state = ST_IDLE;
         endcase
      end else if (w_timeout) begin
         w_next_state = ST_IDLE;
         w_err        = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_wr_q  <= 1'b1;
      end else begin
         r_state <= w_next_state;
         r_wr_q  <= i_wr;
         if (w_strobe || r_state == ST_IDLE) begin
            r_cnt <= '0;
         end else if (r_cnt != TIMEOUT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);  // saturates at the limit
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dir       <= DIR_UP;
         r_moving    <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd_code  <= CMD_STOP;
         r_err       <= 1'b0;
         r_last_byte <= 8'h00;
      end else begin
         r_cmd_valid <= w_fire;
         r_err       <= w_err;
         if (w_strobe) begin
            r_last_byte <= i_data;
         end
         if (w_fire) begin
            r_cmd_code <= w_code;
            if (is_move(w_code)) begin
               r_dir    <= w_code[1:0];
               r_moving <= 1'b1;
            end else begin
               r_moving <= 1'b0;  // stop keeps the last direction
            end
         end
      end
   end

   assign o_dir       = r_dir;
   assign o_moving    = r_moving;
   assign o_cmd_valid = r_cmd_valid;
   assign o_cmd_code  = r_cmd_code;
   assign o_err       = r_err;
   assign o_last_byte = r_last_byte;

endmodule
